// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared widths, ALU/branch operation codes and M-op FSM encoding
// for the execute stage and its multiply/divide sub-unit.
package exe_stage_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int ALU_W  = 5;
    localparam int BR_W   = 3;
    localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD  = 5'd0,  ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
        ALU_MUL  = 5'd16, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [BR_W-1:0] {
        BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL
    } branch_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2
    } state_e;

    function automatic logic is_m_op(input logic [ALU_W-1:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction
endpackage

// File: rtl/exe_stage_mul_div.sv
// mul_div_unit: iterative RV32M engine, 32 steps of shift-add multiply or restoring
// divide; start is a one-cycle pulse and done pulses during the final step.
module mul_div_unit
    import exe_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);
    logic [4:0]  cnt_q, cnt_d;
    logic        active_q, active_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [2:0]  op_q, op_d;
    logic [63:0] mc_q, mc_d, acc_q, acc_d, acc_n, mc_n, prod;
    logic [32:0] mp_q, mp_d, mp_n, sh;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d, res_q, res_d;
    logic [31:0] rem_n, quo_n, q_fix, r_fix, res;
    logic        sa, sb, na, nb, ge;

    always_comb begin
        sa    = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'd3);
        sb    = op_i[2] ? ~op_i[0] : ~op_i[1];
        na    = sa & a_i[31];
        nb    = sb & b_i[31];
        acc_n = acc_q + (mp_q[0] ? mc_q : 64'd0);
        mc_n  = mc_q << 1;
        mp_n  = mp_q >> 1;
        // After 32 steps mp_n[0] is the 33rd (sign) bit of the multiplier: its weight is negative.
        prod  = acc_n - (mp_n[0] ? mc_n : 64'd0);
        sh    = {rem_q, quo_q[31]};
        ge    = sh >= {1'b0, dvs_q};
        rem_n = ge ? sh[31:0] - dvs_q : sh[31:0];
        quo_n = {quo_q[30:0], ge};
        q_fix = dz_q ? '1 : (qneg_q ? -quo_n : quo_n);
        r_fix = dz_q ? dvd_q : (rneg_q ? -rem_n : rem_n);
        res   = op_q[2] ? (op_q[1] ? r_fix : q_fix) : (op_q[1:0] == 2'd0 ? prod[31:0] : prod[63:32]);
    end

    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        dvd_d    = dvd_q;
        res_d    = res_q;
        if (start_i) begin
            cnt_d    = 5'd31;
            active_d = 1'b1;
            op_d     = op_i;
            qneg_d   = na ^ nb;
            rneg_d   = na;
            dz_d     = (b_i == '0);
            mc_d     = {{32{na}}, a_i};
            mp_d     = {nb, b_i};
            acc_d    = '0;
            rem_d    = '0;
            quo_d    = na ? -a_i : a_i;
            dvs_d    = nb ? -b_i : b_i;
            dvd_d    = a_i;
        end else if (active_q) begin
            cnt_d = cnt_q - 5'd1;
            mc_d  = mc_n;
            mp_d  = mp_n;
            acc_d = acc_n;
            rem_d = rem_n;
            quo_d = quo_n;
            if (cnt_q == 5'd0) begin
                active_d = 1'b0;
                res_d    = res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            mc_q     <= '0;
            mp_q     <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            dvd_q    <= '0;
            res_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            mc_q     <= mc_d;
            mp_q     <= mp_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            dvd_q    <= dvd_d;
            res_q    <= res_d;
        end
    end

    assign done_o   = active_q && (cnt_q == 5'd0);
    assign result_o = res_q;
endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage - combinational ALU and branch unit, plus a stalling RV32M
// multiply/divide path that is compiled in only when MULDIV_EN is defined.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_exe,
    input  logic              registerWriteEnable_i,
    input  logic              dataWriteEnable_i,
    input  logic              regSelect_i,
    input  logic [BR_W-1:0]   branchCtr_i,
    input  logic [ALU_W-1:0]  aluCtr_i,
    input  logic [DATA_W-1:0] dataA_i,
    input  logic [DATA_W-1:0] dataB_i,
    input  logic [ADDR_W-1:0] offset_i,
    output logic [DATA_W-1:0] aluResult_o,
    output logic [DATA_W-1:0] storeData_o,
    output logic              registerWriteEnable_o,
    output logic              dataWriteEnable_o,
    output logic              regSelect_o,
    output logic              branchTaken_o,
    output logic [ADDR_W-1:0] branchTarget_o,
    output logic              stall_o
);
    logic [DATA_W-1:0] alu_res, m_result;
    logic              is_m, m_done, stall, eq, lt, ltu, cond;
    logic [4:0]        shamt;

    assign is_m  = is_m_op(aluCtr_i);
    assign shamt = dataB_i[4:0];

    always_comb begin
        case (aluCtr_i)
            ALU_ADD:  alu_res = dataA_i + dataB_i;
            ALU_SUB:  alu_res = dataA_i - dataB_i;
            ALU_AND:  alu_res = dataA_i & dataB_i;
            ALU_OR:   alu_res = dataA_i | dataB_i;
            ALU_XOR:  alu_res = dataA_i ^ dataB_i;
            ALU_SLL:  alu_res = dataA_i << shamt;
            ALU_SRL:  alu_res = dataA_i >> shamt;
            ALU_SRA:  alu_res = $signed(dataA_i) >>> shamt;
            ALU_SLT:  alu_res = {31'd0, $signed(dataA_i) < $signed(dataB_i)};
            ALU_SLTU: alu_res = {31'd0, dataA_i < dataB_i};
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        eq  = dataA_i == dataB_i;
        lt  = $signed(dataA_i) < $signed(dataB_i);
        ltu = dataA_i < dataB_i;
        case (branchCtr_i)
            BR_BEQ:  cond = eq;
            BR_BNE:  cond = ~eq;
            BR_BLT:  cond = lt;
            BR_BGE:  cond = ~lt;
            BR_BLTU: cond = ltu;
            BR_BGEU: cond = ~ltu;
            BR_JAL:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

`ifdef MULDIV_EN
    state_e            state_q, state_d;
    logic              md_start, md_done;
    logic [DATA_W-1:0] md_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        case (state_q)
            S_IDLE:  state_d = is_m ? S_BUSY : S_IDLE;
            S_BUSY:  state_d = md_done ? S_DONE : S_BUSY;
            default: state_d = S_IDLE;
        endcase
    end

    // Reset is folded in so stall drops the moment reset asserts, not at the next edge.
    always_comb begin
        md_start = rst && (state_q == S_IDLE) && is_m;
        stall    = md_start || (rst && (state_q == S_BUSY));
        m_done   = state_q == S_DONE;
        m_result = m_done ? md_result : '0;
    end

    mul_div_unit u_mul_div (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .op_i     (aluCtr_i[2:0]),
        .a_i      (dataA_i),
        .b_i      (dataB_i),
        .done_o   (md_done),
        .result_o (md_result)
    );
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign stall          = 1'b0;
    assign m_done         = 1'b0;
    assign m_result       = '0;
`endif

    // An M op may only write back from DONE, which makes its commit a single cycle.
    assign registerWriteEnable_o = registerWriteEnable_i & ~stall & (~is_m | m_done);
    assign dataWriteEnable_o     = dataWriteEnable_i & ~stall;
    assign regSelect_o           = regSelect_i;
    assign storeData_o           = dataB_i;
    assign stall_o               = stall;
    assign branchTaken_o         = cond & ~stall;
    assign branchTarget_o        = pc_exe + offset_i;
    assign aluResult_o           = is_m ? m_result : (branchCtr_i == BR_JAL ? pc_exe + 32'd4 : alu_res);
endmodule
